// File: rtl/wm_blend_pipe.sv
// wm_blend_pipe: pipelined fixed-point watermark blend out = A*P + B*W with rounding and saturation
module wm_blend_pipe #(
  parameter int Data_Depth  = 8,
  parameter int Coef_Width  = 7,
  parameter int Frac_Bits   = 6,
  parameter int Lanes       = 1,
  parameter int Block_Beats = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [Data_Depth-1:0]         cfg_G_mu_k,
  input  logic [Data_Depth-1:0]         cfg_B_thr,
  input  logic [Coef_Width-1:0]         cfg_A_max,
  input  logic [Coef_Width-1:0]         cfg_B_min,
  input  logic [Coef_Width-1:0]         cfg_A_k,
  input  logic [Coef_Width-1:0]         cfg_B_k,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [Lanes*Data_Depth-1:0]   in_P,
  input  logic [Lanes*Data_Depth-1:0]   in_W,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [Lanes*Data_Depth-1:0]   out_pixel,
  output logic                          out_sat,
  output logic                          out_last
);
  localparam int pw = Data_Depth + Coef_Width;
  localparam int rw = pw + 2;
  localparam int cnt_w = $clog2(Block_Beats + 1);
  localparam logic [rw-1:0] half = rw'((64'd1 << Frac_Bits) >> 1);
  localparam logic [rw-1:0] max_pix = rw'((64'd1 << Data_Depth) - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_d;
  logic [cnt_w-1:0] cnt;
  logic [Coef_Width-1:0] a_sel, b_sel;
  logic advance, cfg_fire, in_fire, last_beat;

  logic s1_v, s1_last;
  logic [Lanes*Data_Depth-1:0] s1_p, s1_w;
  logic [Coef_Width-1:0] s1_a, s1_b;

  logic s2_v, s2_last;
  logic [pw-1:0] s2_pa [Lanes];
  logic [pw-1:0] s2_wb [Lanes];

  logic [rw-1:0] r;
  logic [Lanes*Data_Depth-1:0] pix_d;
  logic sat_d;

  assign advance   = !out_valid || out_ready;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;
  assign last_beat = cnt == cnt_w'(Block_Beats - 1);

  // Block FSM: IDLE waits for a config, RUN accepts exactly one block of beats
  always_comb begin
    state_d   = state;
    cfg_ready = rst && state == IDLE;
    in_ready  = rst && state == RUN && advance;
    state_d   = state == IDLE ? (cfg_valid ? RUN : IDLE)
                              : (in_valid && advance && last_beat ? IDLE : RUN);
  end

  // State register, per-block coefficient selection and beat counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_sel <= '0;
      b_sel <= '0;
    end else begin
      state <= state_d;
      if (cfg_fire) begin
        a_sel <= cfg_G_mu_k >= cfg_B_thr ? cfg_A_max : cfg_A_k;
        b_sel <= cfg_G_mu_k >= cfg_B_thr ? cfg_B_min : cfg_B_k;
        cnt   <= '0;
      end else if (in_fire) begin
        cnt <= last_beat ? '0 : cnt + cnt_w'(1);
      end
    end
  end

  // Stage valids and the registered output bundle; everything holds while stalled
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v      <= 1'b0;
      s1_last   <= 1'b0;
      s2_v      <= 1'b0;
      s2_last   <= 1'b0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_sat   <= 1'b0;
      out_last  <= 1'b0;
    end else if (advance) begin
      s1_v      <= in_fire;
      s1_last   <= in_fire && last_beat;
      s2_v      <= s1_v;
      s2_last   <= s1_last;
      out_valid <= s2_v;
      out_pixel <= pix_d;
      out_sat   <= s2_v && sat_d;
      out_last  <= s2_v && s2_last;
    end
  end

  // Datapath: S1 captures pixels with their own coefficient copy, S2 forms lane products
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_p <= in_P;
      s1_w <= in_W;
      s1_a <= a_sel;
      s1_b <= b_sel;
      for (int i = 0; i < Lanes; i++) begin
        s2_pa[i] <= pw'(s1_a) * pw'(s1_p[i*Data_Depth +: Data_Depth]);
        s2_wb[i] <= pw'(s1_b) * pw'(s1_w[i*Data_Depth +: Data_Depth]);
      end
    end
  end

  // S3 arithmetic: per-lane sum, round half up, drop fraction, clamp to pixel range
  always_comb begin
    pix_d = '0;
    sat_d = 1'b0;
    r     = '0;
    for (int i = 0; i < Lanes; i++) begin
      r = (rw'(s2_pa[i]) + rw'(s2_wb[i]) + half) >> Frac_Bits;
      pix_d[i*Data_Depth +: Data_Depth] = r > max_pix ? {Data_Depth{1'b1}} : r[Data_Depth-1:0];
      sat_d = sat_d || r > max_pix;
    end
  end
endmodule
